tlb: RTL and testbench



---
 rtl/tlb_pkg.sv | 16 +
 rtl/tlb_if.sv | 27 ++
 rtl/tlb_walker.sv | 64 ++++++
 rtl/tlb.sv | 89 ++++++++
 tb/tb_tlb.sv | 124 ++++++++++++
 5 files changed

// File: rtl/tlb_pkg.sv
// Shared defaults and types for the translation lookaside buffer.
package tlb_pkg;

   localparam int unsigned TLB_ENTRIES = 4;
   localparam int unsigned PAGE_WIDTH  = 20;
   localparam int unsigned TLB_DELAY   = 5;

   typedef struct packed {
      logic                  valid;
      logic [PAGE_WIDTH-1:0] vtag;
      logic [PAGE_WIDTH-1:0] ppage;
   } tlb_entry_t;

   typedef enum logic [0:0] {IDLE, WALK} walk_state_t;

endpackage

// File: rtl/tlb_if.sv
// Lookup port between address generation (master) and the TLB (slave).
interface tlb_if
   import tlb_pkg::*;
#(
   parameter int unsigned WIDTH = PAGE_WIDTH
);

   logic [WIDTH-1:0] virtual_page;
   logic [WIDTH-1:0] physical_page_out;
   logic             hit;
   logic             exception;

   modport master (
      output virtual_page,
      input  physical_page_out,
      input  hit,
      input  exception
   );

   modport slave (
      input  virtual_page,
      output physical_page_out,
      output hit,
      output exception
   );

endinterface

// File: rtl/tlb_walker.sv
// Fixed-latency page-table walker: latches a missing page, counts down,
// then presents one fill (translation is vpage + 1) for a single cycle.
module tlb_walker
   import tlb_pkg::*;
#(
   parameter int unsigned WIDTH = PAGE_WIDTH,
   parameter int unsigned DELAY = TLB_DELAY
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             miss,
   input  logic [WIDTH-1:0] vpage,
   output logic             fill_valid,
   output logic [WIDTH-1:0] fill_vpage,
   output logic [WIDTH-1:0] fill_ppage
);

   localparam int unsigned CW = (DELAY > 1) ? $clog2(DELAY) : 1;

   walk_state_t      state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] vpage_q;
   logic [WIDTH-1:0] ppage_q;
   logic             fill_valid_q;

   // fill_valid_q is high exactly while WALK sits at count 0, so the top writes
   // the entry on the edge that ends the walk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         vpage_q      <= '0;
         ppage_q      <= '0;
         fill_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               fill_valid_q <= 1'b0;
               if (miss) begin
                  state_q      <= WALK;
                  cnt_q        <= CW'(DELAY - 1);
                  vpage_q      <= vpage;
                  ppage_q      <= vpage + 1'b1;
                  fill_valid_q <= (DELAY == 1);
               end
            end
            WALK: begin
               if (cnt_q == '0) begin
                  state_q      <= IDLE;
                  fill_valid_q <= 1'b0;
               end else begin
                  cnt_q        <= cnt_q - 1'b1;
                  fill_valid_q <= (cnt_q == CW'(1));
               end
            end
         endcase
      end
   end

   assign fill_valid = fill_valid_q;
   assign fill_vpage = vpage_q;
   assign fill_ppage = ppage_q;

endmodule

// File: rtl/tlb.sv
// Fully associative TLB: combinational lookup, serialised miss walks, and
// first-invalid / round-robin replacement. Entry storage assumes WIDTH == PAGE_WIDTH.
module tlb
   import tlb_pkg::*;
#(
   parameter int unsigned N     = TLB_ENTRIES,
   parameter int unsigned WIDTH = PAGE_WIDTH,
   parameter int unsigned DELAY = TLB_DELAY
) (
   input logic  clk,
   input logic  rst_n,
   tlb_if.slave bus
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   tlb_entry_t       entries_q [N];
   logic [PW-1:0]    rr_q;
   logic [N-1:0]     match;
   logic [WIDTH-1:0] ppage_mux;
   logic             exc;
   logic             hit_w;
   logic             fill_valid;
   logic [WIDTH-1:0] fill_vpage;
   logic [WIDTH-1:0] fill_ppage;
   logic [PW-1:0]    victim;
   logic             use_rr;
   logic             found;

   always_comb begin
      match     = '0;
      ppage_mux = '0;
      for (int i = 0; i < int'(N); i++) begin
         match[i] = entries_q[i].valid && (entries_q[i].vtag == bus.virtual_page);
         if (match[i]) ppage_mux = ppage_mux | entries_q[i].ppage;
      end
   end

   assign exc                   = (bus.virtual_page == '0);
   assign hit_w                 = (|match) && !exc;
   assign bus.exception         = exc;
   assign bus.hit               = hit_w;
   assign bus.physical_page_out = hit_w ? ppage_mux : '0;

   tlb_walker #(
      .WIDTH (WIDTH),
      .DELAY (DELAY)
   ) u_walker (
      .clk        (clk),
      .rst_n      (rst_n),
      .miss       (!hit_w && !exc),
      .vpage      (bus.virtual_page),
      .fill_valid (fill_valid),
      .fill_vpage (fill_vpage),
      .fill_ppage (fill_ppage)
   );

   // Victim: an entry already holding the page, else lowest invalid, else round-robin.
   always_comb begin
      victim = rr_q;
      use_rr = 1'b1;
      found  = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (!found && entries_q[i].valid && (entries_q[i].vtag == fill_vpage)) begin
            victim = PW'(i);
            use_rr = 1'b0;
            found  = 1'b1;
         end
      end
      for (int i = 0; i < int'(N); i++) begin
         if (!found && !entries_q[i].valid) begin
            victim = PW'(i);
            use_rr = 1'b0;
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N); i++) entries_q[i] <= '0;
         rr_q <= '0;
      end else if (fill_valid) begin
         entries_q[victim] <= '{valid: 1'b1, vtag: fill_vpage, ppage: fill_ppage};
         if (use_rr) rr_q <= (rr_q == PW'(N - 1)) ? '0 : rr_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_tlb.sv
// Directed self-checking bench for tlb with hand-computed expectations.
module tb_tlb;
   import tlb_pkg::*;

   localparam int unsigned N     = 4;
   localparam int unsigned WIDTH = 20;
   localparam int unsigned DELAY = 5;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   tlb_if #(.WIDTH(WIDTH)) bus ();

   tlb #(
      .N     (N),
      .WIDTH (WIDTH),
      .DELAY (DELAY)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_vp(input logic [WIDTH-1:0] v);
      bus.virtual_page = v;
      #1;
   endtask

   task automatic lookup(input string tag, input logic [WIDTH-1:0] v, input logic exp_hit,
                         input logic [WIDTH-1:0] exp_pp);
      set_vp(v);
      check({tag, "_hit"}, 32'(bus.hit), 32'(exp_hit));
      check({tag, "_pp"}, 32'(bus.physical_page_out), 32'(exp_pp));
      check({tag, "_exc"}, 32'(bus.exception), 32'(v == '0));
   endtask

   // Miss sampled at the first edge must fill exactly DELAY edges later.
   task automatic fill(input string tag, input logic [WIDTH-1:0] v);
      lookup({tag, "_miss"}, v, 1'b0, '0);
      tick(DELAY);
      check({tag, "_early"}, 32'(bus.hit), 32'd0);
      tick(1);
      check({tag, "_hit"}, 32'(bus.hit), 32'd1);
      check({tag, "_pp"}, 32'(bus.physical_page_out), 32'(WIDTH'(v + 1'b1)));
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      bus.virtual_page = 20'd2;
      tick(2);
      lookup("rst", 20'd2, 1'b0, '0);
      rst_n = 1'b1;
      lookup("post_rst", 20'd2, 1'b0, '0);

      // Page 2 walk starts here; input change mid-walk must not disturb it.
      tick(1);
      lookup("p6_during_walk", 20'd6, 1'b0, '0);
      tick(4);
      lookup("p2_prefill", 20'd2, 1'b0, '0);
      tick(1);
      check("p2_fill_hit", 32'(bus.hit), 32'd1);
      check("p2_fill_pp", 32'(bus.physical_page_out), 32'd3);
      fill("p6", 20'd6);
      lookup("p2_again", 20'd2, 1'b1, 20'd3);

      // Page 0: exception only, no walk, no allocation.
      lookup("zero", 20'd0, 1'b0, '0);
      tick(DELAY + 2);
      lookup("zero_held", 20'd0, 1'b0, '0);
      fill("p3", 20'd3);
      fill("p4", 20'd4);

      // TLB now full {2,6,3,4}; round-robin evicts 2, then 6, then 3.
      fill("p5", 20'd5);
      fill("p7", 20'd7);
      lookup("p2_evicted", 20'd2, 1'b0, '0);
      lookup("p6_evicted", 20'd6, 1'b0, '0);
      lookup("p3_kept", 20'd3, 1'b1, 20'd4);
      lookup("p4_kept", 20'd4, 1'b1, 20'd5);
      lookup("p5_kept", 20'd5, 1'b1, 20'd6);
      fill("pmax", 20'hFFFFF);
      lookup("p3_evicted", 20'd3, 1'b0, '0);
      lookup("p7_kept", 20'd7, 1'b1, 20'd8);

      // Reset in the middle of a page 9 walk.
      lookup("p9_miss", 20'd9, 1'b0, '0);
      tick(3);
      rst_n = 1'b0;
      lookup("in_rst_p4", 20'd4, 1'b0, '0);
      lookup("in_rst_zero", 20'd0, 1'b0, '0);
      tick(1);
      rst_n = 1'b1;
      tick(DELAY + 1);
      lookup("abort_p9", 20'd9, 1'b0, '0);
      lookup("abort_p4", 20'd4, 1'b0, '0);
      lookup("abort_p7", 20'd7, 1'b0, '0);
      lookup("abort_pmax", 20'hFFFFF, 1'b0, '0);
      fill("p9_after_rst", 20'd9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
